// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath mux selects and the instruction classes produced by the decoder.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    R_ALU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  // Static per-instruction controls; no_write marks the sll $0 nop.
  typedef struct packed {
    iclass_t    cls;
    logic       no_write;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_ctr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus the static ALU,
// extender and register-writeback selects that the FSM drives when needed.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: ILL, no_write: 1'b0, alu_src: 1'b0, ext_op: EXT_ZERO,
            alu_ctr: ALU_ADD, reg_dst: DST_RT, mem_to_reg: WD_ALU};
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst = DST_RD;
        case (funct)
          FN_ADDU: dec.cls = R_ALU;
          FN_SUBU: begin
            dec.cls     = R_ALU;
            dec.alu_ctr = ALU_SUB;
          end
          FN_SLL: begin
            dec.cls      = R_ALU;
            dec.no_write = 1'b1;
          end
          FN_JR:   dec.cls = JR;
          default: dec.cls = ILL;
        endcase
      end
      OP_ORI: begin
        dec.cls     = ORI;
        dec.alu_src = 1'b1;
        dec.alu_ctr = ALU_OR;
      end
      // lui passes the upper-extended immediate through an OR with $0
      OP_LUI: begin
        dec.cls     = LUI;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_UPPER;
        dec.alu_ctr = ALU_OR;
      end
      OP_LW: begin
        dec.cls        = LW;
        dec.alu_src    = 1'b1;
        dec.ext_op     = EXT_SIGN;
        dec.mem_to_reg = WD_MEM;
      end
      OP_SW: begin
        dec.cls     = SW;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_SIGN;
      end
      OP_BEQ: begin
        dec.cls     = BEQ;
        dec.ext_op  = EXT_SIGN;
        dec.alu_ctr = ALU_SUB;
      end
      OP_J: dec.cls = J;
      OP_JAL: begin
        dec.cls        = JAL;
        dec.reg_dst    = DST_RA;
        dec.mem_to_reg = WD_PC4;
      end
      default: dec.cls = ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory wait-state handshakes, a per-handshake timeout and a sticky error state.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] ext_op,
  output logic [2:0] alu_ctr,
  output logic [2:0] state_o,
  output logic       instr_done,
  output logic       err
);

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       waiting, wait_expired;
  dec_t       dec;

  mc_ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  assign waiting      = (state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready);
  assign wait_expired = waiting && (wait_cnt == WAIT_LIMIT);

  // Every state change clears the counter, so FETCH and MEM always start at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= 8'd0;
      else if (waiting)       wait_cnt <= wait_cnt + 8'd1;
      if (state_nxt == S_ERR) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)        state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_ERR;
      end
      S_DECODE: begin
        case (dec.cls)
          J, JAL, JR: state_nxt = S_FETCH;
          ILL:        state_nxt = S_ERR;
          default:    state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (dec.cls)
          BEQ:     state_nxt = S_FETCH;
          LW, SW:  state_nxt = S_MEM;
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)        state_nxt = (dec.cls == SW) ? S_FETCH : S_WB;
        else if (wait_expired) state_nxt = S_ERR;
      end
      S_WB:    state_nxt = S_FETCH;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WD_ALU;
    alu_src    = 1'b0;
    ext_op     = EXT_ZERO;
    alu_ctr    = ALU_ADD;
    instr_done = 1'b0;
    state_o    = state;
    err        = err_q;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      alu_src = dec.alu_src;
      ext_op  = dec.ext_op;
      alu_ctr = dec.alu_ctr;
    end
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        pc_we    = imem_ready;
      end
      S_DECODE: begin
        case (dec.cls)
          J: begin
            pc_we      = 1'b1;
            pc_sel     = PC_JUMP;
            instr_done = 1'b1;
          end
          JAL: begin
            pc_we      = 1'b1;
            pc_sel     = PC_JUMP;
            reg_we     = 1'b1;
            reg_dst    = dec.reg_dst;
            mem_to_reg = dec.mem_to_reg;
            instr_done = 1'b1;
          end
          JR: begin
            pc_we      = 1'b1;
            pc_sel     = PC_REG;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        if (dec.cls == BEQ) begin
          pc_we      = zero;
          pc_sel     = PC_BRANCH;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = (dec.cls == SW);
        instr_done = (dec.cls == SW) && dmem_ready;
      end
      S_WB: begin
        reg_we     = !dec.no_write;
        reg_dst    = dec.reg_dst;
        mem_to_reg = dec.mem_to_reg;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
